ff_roi_exerciser: RTL and testbench

- Drives and reads back an array of fixed-placement flops under test, the region-of-interest flops in our fuzzer minitests, through a small serial pin budget.
- Shifts a stimulus frame in serially and applies it to the D, CE and CLR inputs of the flops.
- Waits a settle interval, captures the flops' Q outputs, and shifts them back out serially.
- It is the writer/reader pair sitting on the other side of each FDCE instance, so a handful of top-level pins can exercise many placed flops.

---
 rtl/ff_roi_exerciser.sv | 119 +++++++++++
 tb/tb_ff_roi_exerciser.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_roi_exerciser.sv
// Serial writer/reader for an array of placed flops under test: loads a D/CE/CLR
// frame over one pin, applies it, waits a settle interval, then shifts Q back out.
module ff_roi_exerciser #(
  parameter int N_FF   = 8,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sin,
  output logic [N_FF-1:0] ff_d,
  output logic [N_FF-1:0] ff_ce,
  output logic [N_FF-1:0] ff_clr,
  input  logic [N_FF-1:0] ff_q,
  output logic            sout,
  output logic            sout_valid,
  output logic            busy,
  output logic            done
);

  localparam int STIM_W = 3 * N_FF;
  localparam int BIT_CW = $clog2(STIM_W + 1);
  localparam int SET_CW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    CAPTURE,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [STIM_W-1:0]   stim;
  logic [BIT_CW-1:0]   bit_cnt;
  logic [SET_CW-1:0]   settle_cnt;
  logic [N_FF-1:0]     cap;

  logic load_last;
  logic settle_last;
  logic shift_last;

  assign load_last   = (bit_cnt == BIT_CW'(STIM_W - 1));
  assign settle_last = (settle_cnt == SET_CW'(SETTLE - 1));
  assign shift_last  = (bit_cnt == BIT_CW'(N_FF - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (load_last) state_next = APPLY;
      APPLY:   state_next = CAPTURE;
      CAPTURE: if (settle_last) state_next = SHIFT;
      SHIFT:   if (shift_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit 0 of the capture goes straight to sout on the sample edge so the first
  // readback bit is on the pin during the first SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stim       <= '0;
      bit_cnt    <= '0;
      settle_cnt <= '0;
      cap        <= '0;
      ff_d       <= '0;
      ff_ce      <= '0;
      ff_clr     <= '1;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
        end
        LOAD: begin
          stim    <= {sin, stim[STIM_W-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        APPLY: begin
          ff_d       <= stim[N_FF-1:0];
          ff_ce      <= stim[2*N_FF-1:N_FF];
          ff_clr     <= stim[STIM_W-1:2*N_FF];
          settle_cnt <= '0;
        end
        CAPTURE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_last) begin
            cap        <= ff_q >> 1;
            sout       <= ff_q[0];
            sout_valid <= 1'b1;
            bit_cnt    <= '0;
          end
        end
        SHIFT: begin
          sout    <= cap[0];
          cap     <= cap >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (shift_last) begin
            sout       <= 1'b0;
            sout_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_ff_roi_exerciser.sv
// Bench for ff_roi_exerciser: a frame-level reference model checks every cycle,
// directed frames pin literal results, then randomized frames follow.
module tb_ff_roi_exerciser;

  localparam int N   = 8;
  localparam int S   = 2;
  localparam int FL  = 3 * N + 1 + S + N + 1;
  localparam int SH0 = 3 * N + S + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sin = 1'b0;
  logic [N-1:0] ff_d, ff_ce, ff_clr, ff_q;
  logic         sout, sout_valid, busy, done;
  logic         loop_mode = 1'b1;
  logic [N-1:0] fdce_reg, fdce_q;

  logic         start1 = 1'b0;
  logic         sin1 = 1'b0;
  logic [0:0]   ff_d1, ff_ce1, ff_clr1;
  logic         sout1, sout_valid1, busy1, done1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FDCE array: async clear modelled by masking the held state.
  always @(posedge clk) fdce_reg <= ~ff_clr & ((ff_ce & ff_d) | (~ff_ce & fdce_reg));
  assign fdce_q = fdce_reg & ~ff_clr;
  assign ff_q   = loop_mode ? ff_d : fdce_q;

  ff_roi_exerciser #(.N_FF(N), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .sin(sin),
    .ff_d(ff_d), .ff_ce(ff_ce), .ff_clr(ff_clr), .ff_q(ff_q),
    .sout(sout), .sout_valid(sout_valid), .busy(busy), .done(done)
  );

  ff_roi_exerciser #(.N_FF(1), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sin(sin1),
    .ff_d(ff_d1), .ff_ce(ff_ce1), .ff_clr(ff_clr1), .ff_q(ff_d1),
    .sout(sout1), .sout_valid(sout_valid1), .busy(busy1), .done(done1)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: k is the cycle offset since the start edge (0 = idle).
  int           k = 0;
  logic         armed = 1'b0;
  logic         exp_v;
  logic [3*N-1:0] m_stim;
  logic [N-1:0] m_d, m_ce, m_clr, m_fq, m_rb;

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        exp_v = (k >= SH0) && (k < SH0 + N);
        checkOutput("busy", 64'(busy), 64'(k != 0));
        checkOutput("done", 64'(done), 64'(k == FL));
        checkOutput("sout_valid", 64'(sout_valid), 64'(exp_v));
        if (exp_v) checkOutput("sout", 64'(sout), 64'(m_rb[k-SH0]));
        checkOutput("ff_d", 64'(ff_d), 64'(m_d));
        checkOutput("ff_ce", 64'(ff_ce), 64'(m_ce));
        checkOutput("ff_clr", 64'(ff_clr), 64'(m_clr));
      end
      if (rst) begin
        armed = 1'b1;
        k     = 0;
        m_d   = '0;
        m_ce  = '0;
        m_clr = '1;
        m_fq  = '0;
      end else if (armed) begin
        if (k == 0) begin
          if (start) k = 1;
        end else begin
          if (k <= 3 * N) m_stim[k-1] = sin;
          if (k == 3 * N + 1) begin
            m_d   = m_stim[N-1:0];
            m_ce  = m_stim[2*N-1:N];
            m_clr = m_stim[3*N-1:2*N];
            m_fq  = ~m_clr & ((m_ce & m_d) | (~m_ce & m_fq));
            m_rb  = loop_mode ? m_d : m_fq;
          end
          k = (k == FL) ? 0 : k + 1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [N-1:0] d, input logic [N-1:0] ce, input logic [N-1:0] clr,
                               input logic lb, input logic extra, input int abort_at,
                               output logic [N-1:0] rb, output int lat, output int nbits,
                               output logic got_done, output logic [N-1:0] d_apply);
    logic [3*N-1:0] stim;
    int c0;
    stim      = {clr, ce, d};
    loop_mode = lb;
    rb        = '0;
    nbits     = 0;
    got_done  = 1'b0;
    d_apply   = '0;
    lat       = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 3 * N; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      sin   = stim[i];
      start = extra && (i == 4);
    end
    for (int n = 0; n < 100 && !got_done; n++) begin
      @(posedge clk); #1;
      lat   = cyc - c0 + 1;
      start = extra && (lat == 26 || lat == FL);
      sin   = 1'($urandom);
      rst   = (abort_at != 0) && (lat == abort_at || lat == abort_at + 1);
      @(negedge clk);
      if (lat == 3 * N + 1) d_apply = ff_d;
      if (sout_valid) begin
        if (nbits < N) rb[nbits] = sout;
        nbits++;
      end
      if (done) got_done = 1'b1;
      if (abort_at != 0 && lat == abort_at + 2) break;
    end
    rst = 1'b0;
    if (extra) begin
      @(posedge clk); #1 start = 1'b0;
    end
  endtask

  task automatic applyStimulusSmall(input logic d, input logic ce, input logic clr,
                                    output int nvalid, output logic bitv, output int lat,
                                    output logic got_done);
    int c0;
    nvalid   = 0;
    bitv     = 1'b0;
    got_done = 1'b0;
    lat      = 0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    c0 = cyc;
    sin1 = d;
    @(posedge clk); #1 sin1 = ce;
    @(posedge clk); #1 sin1 = clr;
    for (int n = 0; n < 50 && !got_done; n++) begin
      @(posedge clk); #1;
      lat = cyc - c0 + 1;
      @(negedge clk);
      if (sout_valid1) begin
        nvalid++;
        bitv = sout1;
      end
      if (done1) got_done = 1'b1;
    end
  endtask

  task automatic pulseReset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  logic [N-1:0] rb, d_apply;
  int           lat, nbits, nvalid;
  logic         got_done, bitv;

  initial begin
    pulseReset();
    @(negedge clk);
    checkOutput("reset_ff_clr", 64'(ff_clr), 64'hFF);
    checkOutput("reset_ff_d", 64'(ff_d), 64'h0);
    checkOutput("reset_ff_ce", 64'(ff_ce), 64'h0);
    checkOutput("reset_busy", 64'(busy), 64'h0);
    checkOutput("reset_sout_valid", 64'(sout_valid), 64'h0);

    applyStimulus(8'hA5, 8'hFF, 8'h00, 1'b1, 1'b0, 0, rb, lat, nbits, got_done, d_apply);
    checkOutput("loopback_rb", 64'(rb), 64'hA5);
    checkOutput("loopback_done_seen", 64'(got_done), 64'h1);
    checkOutput("loopback_latency", 64'(lat), 64'd36);
    checkOutput("loopback_nbits", 64'(nbits), 64'd8);

    pulseReset();
    applyStimulus(8'h0F, 8'h03, 8'h80, 1'b0, 1'b0, 0, rb, lat, nbits, got_done, d_apply);
    checkOutput("fdce_rb", 64'(rb), 64'h03);

    applyStimulus(8'hA5, 8'hFF, 8'h00, 1'b1, 1'b1, 0, rb, lat, nbits, got_done, d_apply);
    checkOutput("ignored_start_rb", 64'(rb), 64'hA5);
    checkOutput("ignored_start_latency", 64'(lat), 64'd36);
    checkOutput("ignored_start_nbits", 64'(nbits), 64'd8);

    applyStimulus(8'h3C, 8'hFF, 8'h00, 1'b1, 1'b0, 0, rb, lat, nbits, got_done, d_apply);
    checkOutput("b2b_rb1", 64'(rb), 64'h3C);
    applyStimulus(8'hC3, 8'hFF, 8'h00, 1'b1, 1'b0, 0, rb, lat, nbits, got_done, d_apply);
    checkOutput("b2b_rb2", 64'(rb), 64'hC3);
    checkOutput("b2b_hold_at_apply", 64'(d_apply), 64'h3C);
    checkOutput("b2b_latency", 64'(lat), 64'd36);

    applyStimulus(8'h5A, 8'hFF, 8'h00, 1'b1, 1'b0, 30, rb, lat, nbits, got_done, d_apply);
    checkOutput("abort_ff_clr", 64'(ff_clr), 64'hFF);
    checkOutput("abort_ff_d", 64'(ff_d), 64'h0);
    checkOutput("abort_ff_ce", 64'(ff_ce), 64'h0);
    checkOutput("abort_sout_valid", 64'(sout_valid), 64'h0);
    checkOutput("abort_busy", 64'(busy), 64'h0);
    applyStimulus(8'h96, 8'hFF, 8'h00, 1'b1, 1'b0, 0, rb, lat, nbits, got_done, d_apply);
    checkOutput("after_abort_rb", 64'(rb), 64'h96);
    checkOutput("after_abort_latency", 64'(lat), 64'd36);

    applyStimulusSmall(1'b1, 1'b1, 1'b0, nvalid, bitv, lat, got_done);
    checkOutput("n1_nvalid", 64'(nvalid), 64'd1);
    checkOutput("n1_sout", 64'(bitv), 64'h1);
    checkOutput("n1_latency", 64'(lat), 64'd7);
    applyStimulusSmall(1'b0, 1'b1, 1'b0, nvalid, bitv, lat, got_done);
    checkOutput("n1_zero_sout", 64'(bitv), 64'h0);
    checkOutput("n1_zero_latency", 64'(lat), 64'd7);

    for (int f = 0; f < 30; f++) begin
      int gap;
      int abort_at;
      gap      = int'($urandom_range(0, 3));
      abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(25, 33)) : 0;
      repeat (gap) @(posedge clk);
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                    abort_at, rb, lat, nbits, got_done, d_apply);
      if (abort_at == 0) begin
        checkOutput("rand_done_seen", 64'(got_done), 64'h1);
        checkOutput("rand_latency", 64'(lat), 64'd36);
      end
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
